// File: rtl/synchronous_true_dual_port_ram_pkg.sv
// Shared encodings for the dual-port RAM family: cross-port read-during-write
// selection, write-write collision priority and the clear sequencer state.
package synchronous_true_dual_port_ram_pkg;

    // READ_DURING_WRITE encodings
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // COLLISION_PRIORITY encodings
    localparam int COLLISION_PORT_0 = 0;
    localparam int COLLISION_PORT_1 = 1;

    typedef enum logic {
        CLEAR_CLEARING = 1'b0,
        CLEAR_READY    = 1'b1
    } clear_state_t;

endpackage

// File: rtl/synchronous_true_dual_port_ram_clear_sequencer.sv
// Post-reset clear sequencer: walks every word address once, asserting a
// write strobe per word, then raises ready until the next reset.
module memory_clear_sequencer
    import synchronous_true_dual_port_ram_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    output logic                     o_ready,
    output logic [ADDRESS_WIDTH-1:0] o_clear_address,
    output logic                     o_clear_write
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);

    clear_state_t             r_state;
    clear_state_t             w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_count;
    logic [ADDRESS_WIDTH-1:0] w_next_count;

    // State and counter register; reset restarts the clear from word 0
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= CLEAR_CLEARING;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // Next-state: advance one word per cycle, leave after the last word
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            CLEAR_CLEARING: begin
                if (r_count == LAST_ADDRESS) begin
                    w_next_state = CLEAR_READY;
                end else begin
                    w_next_count = r_count + 1'b1;
                end
            end
            CLEAR_READY: begin
                w_next_state = CLEAR_READY;
            end
            default: begin
                w_next_state = CLEAR_CLEARING;
                w_next_count = '0;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        o_clear_write   = (r_state == CLEAR_CLEARING);
        o_ready         = (r_state == CLEAR_READY);
        o_clear_address = r_count;
    end

endmodule

// File: rtl/synchronous_true_dual_port_ram.sv
// Single-clock true dual-port RAM with per-byte write enables, selectable
// cross-port read-during-write, priority-resolved write collisions and a
// hardware clear after reset. Read latency is 1 or 2 cycles.
module synchronous_true_dual_port_ram
    import synchronous_true_dual_port_ram_pkg::*;
#(
    parameter int               WIDTH              = 8,
    parameter int               DEPTH              = 16,
    parameter int               BYTE_WIDTH         = 8,
    parameter int               OUTPUT_REGISTER    = 0,
    parameter int               READ_DURING_WRITE  = RDW_OLD,
    parameter int               COLLISION_PRIORITY = COLLISION_PORT_0,
    parameter logic [WIDTH-1:0] RESET_VALUE        = '0,
    parameter int               ADDRESS_WIDTH      = $clog2(DEPTH),
    parameter int               BYTE_COUNT         = WIDTH / BYTE_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     ready,
    input  logic                     port_0_access_enable,
    input  logic                     port_0_write,
    input  logic [ADDRESS_WIDTH-1:0] port_0_address,
    input  logic [WIDTH-1:0]         port_0_write_data,
    input  logic [BYTE_COUNT-1:0]    port_0_byte_enable,
    output logic [WIDTH-1:0]         port_0_read_data,
    output logic                     port_0_read_valid,
    input  logic                     port_1_access_enable,
    input  logic                     port_1_write,
    input  logic [ADDRESS_WIDTH-1:0] port_1_address,
    input  logic [WIDTH-1:0]         port_1_write_data,
    input  logic [BYTE_COUNT-1:0]    port_1_byte_enable,
    output logic [WIDTH-1:0]         port_1_read_data,
    output logic                     port_1_read_valid,
    output logic                     write_collision
);

    localparam int unsigned HIGH_PORT = (COLLISION_PRIORITY == COLLISION_PORT_1) ? 1 : 0;
    localparam int unsigned LOW_PORT  = 1 - HIGH_PORT;

    logic [WIDTH-1:0]         r_memory [DEPTH];

    logic                     w_ready;
    logic [ADDRESS_WIDTH-1:0] w_clear_address;
    logic                     w_clear_write;
    logic                     w_active;

    logic [1:0]               w_access;
    logic [1:0]               w_write;
    logic [ADDRESS_WIDTH-1:0] w_address     [2];
    logic [WIDTH-1:0]         w_write_data  [2];
    logic [BYTE_COUNT-1:0]    w_byte_enable [2];

    logic [1:0]               w_in_range;
    logic [1:0]               w_do_write;
    logic [1:0]               w_do_read;
    logic [WIDTH-1:0]         w_read_word   [2];
    logic                     w_collision_now;

    logic [1:0]               r_s1_valid;
    logic [WIDTH-1:0]         r_s1_data     [2];
    logic [1:0]               w_out_valid;
    logic [WIDTH-1:0]         w_out_data    [2];
    logic                     r_collision;

    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0]      old_word,
        input logic [WIDTH-1:0]      new_word,
        input logic [BYTE_COUNT-1:0] mask
    );
        logic [WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < BYTE_COUNT; b++) begin
            if (mask[b]) begin
                merged[b*BYTE_WIDTH +: BYTE_WIDTH] = new_word[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return merged;
    endfunction

    memory_clear_sequencer #(
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_clear_sequencer (
        .i_clock         (clock),
        .i_reset         (reset),
        .o_ready         (w_ready),
        .o_clear_address (w_clear_address),
        .o_clear_write   (w_clear_write)
    );

    assign ready            = w_ready;
    assign w_active         = w_ready & ~reset;
    assign w_access         = {port_1_access_enable, port_0_access_enable};
    assign w_write          = {port_1_write, port_0_write};
    assign w_address[0]     = port_0_address;
    assign w_address[1]     = port_1_address;
    assign w_write_data[0]  = port_0_write_data;
    assign w_write_data[1]  = port_1_write_data;
    assign w_byte_enable[0] = port_0_byte_enable;
    assign w_byte_enable[1] = port_1_byte_enable;

    // Per-port request qualification and address range check
    always_comb begin
        w_in_range = '0;
        w_do_write = '0;
        w_do_read  = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            w_in_range[p] = 32'(w_address[p]) < 32'(DEPTH);
            w_do_write[p] = w_active & w_access[p] & w_write[p] & w_in_range[p];
            w_do_read[p]  = w_active & w_access[p] & ~w_write[p];
        end
    end

    // Read word per port, optionally forwarding the other port's same-address write
    always_comb begin
        w_read_word = '{default: '0};
        for (int unsigned p = 0; p < 2; p++) begin
            w_read_word[p] = w_in_range[p] ? r_memory[w_address[p]] : '0;
            if (READ_DURING_WRITE == RDW_NEW && w_do_write[1-p] &&
                w_address[1-p] == w_address[p]) begin
                w_read_word[p] = f_merge(w_read_word[p], w_write_data[1-p], w_byte_enable[1-p]);
            end
        end
    end

    // Collision only when both ports write the same word with overlapping masks
    always_comb begin
        w_collision_now = w_do_write[0] & w_do_write[1] &
                          (w_address[0] == w_address[1]) &
                          (|(w_byte_enable[0] & w_byte_enable[1]));
    end

    // Memory array: clear writes, otherwise byte-masked port writes.
    // The priority port is issued last so its bytes win on overlap.
    always_ff @(posedge clock) begin
        if (w_clear_write) begin
            r_memory[w_clear_address] <= RESET_VALUE;
        end else begin
            for (int unsigned b = 0; b < BYTE_COUNT; b++) begin
                if (w_do_write[LOW_PORT] && w_byte_enable[LOW_PORT][b]) begin
                    r_memory[w_address[LOW_PORT]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                        w_write_data[LOW_PORT][b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
            for (int unsigned b = 0; b < BYTE_COUNT; b++) begin
                if (w_do_write[HIGH_PORT] && w_byte_enable[HIGH_PORT][b]) begin
                    r_memory[w_address[HIGH_PORT]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                        w_write_data[HIGH_PORT][b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage; data only updates on a read so it holds otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= '0;
            r_s1_data  <= '{default: '0};
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                r_s1_valid[p] <= w_do_read[p];
                if (w_do_read[p]) begin
                    r_s1_data[p] <= w_read_word[p];
                end
            end
        end
    end

    generate
        if (OUTPUT_REGISTER != 0) begin : g_output_register
            logic [1:0]       r_s2_valid;
            logic [WIDTH-1:0] r_s2_data [2];

            // Optional second read stage for latency 2
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_s2_valid <= '0;
                    r_s2_data  <= '{default: '0};
                end else begin
                    r_s2_valid <= r_s1_valid;
                    for (int unsigned p = 0; p < 2; p++) begin
                        if (r_s1_valid[p]) begin
                            r_s2_data[p] <= r_s1_data[p];
                        end
                    end
                end
            end

            assign w_out_valid   = r_s2_valid;
            assign w_out_data[0] = r_s2_data[0];
            assign w_out_data[1] = r_s2_data[1];
        end else begin : g_direct_output
            assign w_out_valid   = r_s1_valid;
            assign w_out_data[0] = r_s1_data[0];
            assign w_out_data[1] = r_s1_data[1];
        end
    endgenerate

    // Registered one-cycle collision flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_collision_now;
        end
    end

    assign port_0_read_valid = w_out_valid[0];
    assign port_1_read_valid = w_out_valid[1];
    assign port_0_read_data  = w_out_data[0];
    assign port_1_read_data  = w_out_data[1];
    assign write_collision   = r_collision;

endmodule

// File: tb/tb_synchronous_true_dual_port_ram.sv
// Two RAM instances with different configurations share one stimulus stream;
// each is checked against its own array-based reference model.
module tb_synchronous_true_dual_port_ram;

    localparam int          DEP  [2] = '{16, 12};
    localparam int          OREG [2] = '{0, 1};
    localparam int          RDW  [2] = '{0, 1};
    localparam int          CPRI [2] = '{1, 0};
    localparam logic [15:0] RV   [2] = '{16'hA5A5, 16'h3C3C};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en   [2] = '{1'b0, 1'b0};
    logic        wr   [2] = '{1'b0, 1'b0};
    logic [3:0]  addr [2] = '{4'd0, 4'd0};
    logic [15:0] wd   [2] = '{16'd0, 16'd0};
    logic [1:0]  be   [2] = '{2'd0, 2'd0};

    logic        rdy_o [2];
    logic        col_o [2];
    logic        vld_o [2][2];
    logic [15:0] rd_o  [2][2];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    synchronous_true_dual_port_ram #(
        .WIDTH(16), .DEPTH(16), .BYTE_WIDTH(8), .OUTPUT_REGISTER(0),
        .READ_DURING_WRITE(0), .COLLISION_PRIORITY(1), .RESET_VALUE(16'hA5A5)
    ) u_dut_a (
        .clock(clk), .reset(rst), .ready(rdy_o[0]),
        .port_0_access_enable(en[0]), .port_0_write(wr[0]), .port_0_address(addr[0]),
        .port_0_write_data(wd[0]), .port_0_byte_enable(be[0]),
        .port_0_read_data(rd_o[0][0]), .port_0_read_valid(vld_o[0][0]),
        .port_1_access_enable(en[1]), .port_1_write(wr[1]), .port_1_address(addr[1]),
        .port_1_write_data(wd[1]), .port_1_byte_enable(be[1]),
        .port_1_read_data(rd_o[0][1]), .port_1_read_valid(vld_o[0][1]),
        .write_collision(col_o[0])
    );

    synchronous_true_dual_port_ram #(
        .WIDTH(16), .DEPTH(12), .BYTE_WIDTH(8), .OUTPUT_REGISTER(1),
        .READ_DURING_WRITE(1), .COLLISION_PRIORITY(0), .RESET_VALUE(16'h3C3C)
    ) u_dut_b (
        .clock(clk), .reset(rst), .ready(rdy_o[1]),
        .port_0_access_enable(en[0]), .port_0_write(wr[0]), .port_0_address(addr[0]),
        .port_0_write_data(wd[0]), .port_0_byte_enable(be[0]),
        .port_0_read_data(rd_o[1][0]), .port_0_read_valid(vld_o[1][0]),
        .port_1_access_enable(en[1]), .port_1_write(wr[1]), .port_1_address(addr[1]),
        .port_1_write_data(wd[1]), .port_1_byte_enable(be[1]),
        .port_1_read_data(rd_o[1][1]), .port_1_read_valid(vld_o[1][1]),
        .write_collision(col_o[1])
    );

    // ---------------- reference model ----------------
    logic [15:0] m_mem [2][16];
    int          m_cnt [2];
    logic        m_s1v [2][2];
    logic [15:0] m_s1d [2][2];
    logic        e_rdy [2];
    logic        e_col [2];
    logic        e_vld [2][2];
    logic [15:0] e_dat [2][2];
    logic        md_rdy;
    logic        md_inr [2];
    logic        md_wen [2];
    logic        md_req [2];
    logic [15:0] md_new [2];

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] d,
                                            input logic [1:0] m);
        logic [15:0] r;
        r = old;
        for (int b = 0; b < 2; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] = 0;
                e_rdy[i] = 1'b0;
                e_col[i] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    m_s1v[i][p] = 1'b0; m_s1d[i][p] = 16'h0;
                    e_vld[i][p] = 1'b0; e_dat[i][p] = 16'h0;
                end
            end else begin
                md_rdy = (m_cnt[i] >= DEP[i]);
                for (int p = 0; p < 2; p++) begin
                    md_inr[p] = int'(addr[p]) < DEP[i];
                    md_wen[p] = md_rdy && en[p] && wr[p] && md_inr[p];
                    md_req[p] = md_rdy && en[p] && !wr[p];
                end
                for (int p = 0; p < 2; p++) begin
                    md_new[p] = md_inr[p] ? m_mem[i][addr[p]] : 16'h0;
                    if (RDW[i] == 1 && md_wen[1-p] && addr[1-p] == addr[p])
                        md_new[p] = merge16(md_new[p], wd[1-p], be[1-p]);
                end
                e_col[i] = md_wen[0] && md_wen[1] && addr[0] == addr[1] && ((be[0] & be[1]) != 2'b00);
                if (!md_rdy) begin
                    m_mem[i][m_cnt[i]] = RV[i];
                    m_cnt[i] = m_cnt[i] + 1;
                end else begin
                    if (md_wen[1-CPRI[i]])
                        m_mem[i][addr[1-CPRI[i]]] = merge16(m_mem[i][addr[1-CPRI[i]]], wd[1-CPRI[i]], be[1-CPRI[i]]);
                    if (md_wen[CPRI[i]])
                        m_mem[i][addr[CPRI[i]]] = merge16(m_mem[i][addr[CPRI[i]]], wd[CPRI[i]], be[CPRI[i]]);
                end
                for (int p = 0; p < 2; p++) begin
                    if (OREG[i] == 0) begin
                        e_vld[i][p] = md_req[p];
                        if (md_req[p]) e_dat[i][p] = md_new[p];
                    end else begin
                        e_vld[i][p] = m_s1v[i][p];
                        if (m_s1v[i][p]) e_dat[i][p] = m_s1d[i][p];
                        m_s1v[i][p] = md_req[p];
                        if (md_req[p]) m_s1d[i][p] = md_new[p];
                    end
                end
                e_rdy[i] = (m_cnt[i] >= DEP[i]);
            end
        end
    end

    // ---------------- stimulus utilities ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en[0] = 1'b0; en[1] = 1'b0;
        wr[0] = 1'b0; wr[1] = 1'b0;
    endtask

    task automatic drive(input int p, input logic w, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        en[p] = 1'b1; wr[p] = w; addr[p] = a; wd[p] = d; be[p] = m;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int   rise [2];
        logic spur [2];
        rst = 1'b1;
        idle();
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++; if (rdy_o[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ready inst%0d: got %b want 0", i, rdy_o[i]); end
            n_run++; if (col_o[i] !== 1'b0) begin n_fail++; $display("FAIL reset_collision inst%0d: got %b want 0", i, col_o[i]); end
            for (int p = 0; p < 2; p++) begin
                n_run++; if (vld_o[i][p] !== 1'b0) begin n_fail++; $display("FAIL reset_valid inst%0d port%0d: got %b want 0", i, p, vld_o[i][p]); end
                n_run++; if (rd_o[i][p] !== 16'h0) begin n_fail++; $display("FAIL reset_data inst%0d port%0d: got %h want 0000", i, p, rd_o[i][p]); end
            end
        end
        rst = 1'b0;
        rise = '{0, 0};
        spur = '{1'b0, 1'b0};
        for (int n = 1; n <= 40; n++) begin
            if (n <= 12) begin
                drive(0, 1'b1, 4'(n - 1), 16'hFFFF, 2'b11);
                drive(1, 1'b0, 4'(n - 1), 16'h0, 2'b00);
            end else begin
                idle();
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                if (rise[i] == 0 && rdy_o[i] === 1'b1) rise[i] = n;
                if (rise[i] == 0 && (vld_o[i][0] !== 1'b0 || vld_o[i][1] !== 1'b0 || col_o[i] !== 1'b0)) spur[i] = 1'b1;
            end
            if (rise[0] != 0 && rise[1] != 0) break;
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            n_run++; if (rise[i] != DEP[i]) begin n_fail++; $display("FAIL clear_duration inst%0d: got %0d want %0d", i, rise[i], DEP[i]); end
            n_run++; if (spur[i] !== 1'b0) begin n_fail++; $display("FAIL clear_ignores_access inst%0d: got %b want 0", i, spur[i]); end
        end
    endtask

    task automatic test_clear_readback();
        logic [15:0] exp_b;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) drive(0, 1'b0, 4'(k), 16'h0, 2'b00);
            else idle();
            tick();
            if (k < 16) begin
                n_run++; if (vld_o[0][0] !== 1'b1 || rd_o[0][0] !== 16'hA5A5) begin n_fail++;
                    $display("FAIL readback_a addr%0d: got %b/%h want 1/a5a5", k, vld_o[0][0], rd_o[0][0]); end
            end
            if (k >= 1) begin
                exp_b = (k - 1 < 12) ? 16'h3C3C : 16'h0000;
                n_run++; if (vld_o[1][0] !== 1'b1 || rd_o[1][0] !== exp_b) begin n_fail++;
                    $display("FAIL readback_b addr%0d: got %b/%h want 1/%h", k - 1, vld_o[1][0], rd_o[1][0], exp_b); end
            end
        end
        tick();
        n_run++; if (vld_o[0][0] !== 1'b0 || rd_o[0][0] !== 16'hA5A5) begin n_fail++;
            $display("FAIL hold_a: got %b/%h want 0/a5a5", vld_o[0][0], rd_o[0][0]); end
        n_run++; if (vld_o[1][0] !== 1'b0 || rd_o[1][0] !== 16'h0000) begin n_fail++;
            $display("FAIL hold_b: got %b/%h want 0/0000", vld_o[1][0], rd_o[1][0]); end
    endtask

    task automatic test_byte_enable();
        idle();
        drive(0, 1'b1, 4'd3, 16'h1122, 2'b01);
        tick();
        n_run++; if (vld_o[0][0] !== 1'b0) begin n_fail++; $display("FAIL write_no_valid: got %b want 0", vld_o[0][0]); end
        idle();
        drive(1, 1'b0, 4'd3, 16'h0, 2'b00);
        tick();
        idle();
        n_run++; if (vld_o[0][1] !== 1'b1 || rd_o[0][1] !== 16'hA522) begin n_fail++;
            $display("FAIL byte_enable_a: got %b/%h want 1/a522", vld_o[0][1], rd_o[0][1]); end
        tick();
        n_run++; if (vld_o[1][1] !== 1'b1 || rd_o[1][1] !== 16'h3C22) begin n_fail++;
            $display("FAIL byte_enable_b: got %b/%h want 1/3c22", vld_o[1][1], rd_o[1][1]); end
    endtask

    task automatic test_read_during_write();
        idle();
        drive(0, 1'b1, 4'd5, 16'h0010, 2'b11);
        tick();
        drive(0, 1'b1, 4'd5, 16'h0020, 2'b11);
        drive(1, 1'b0, 4'd5, 16'h0, 2'b00);
        tick();
        idle();
        n_run++; if (rd_o[0][1] !== 16'h0010) begin n_fail++; $display("FAIL rdw_old: got %h want 0010", rd_o[0][1]); end
        tick();
        n_run++; if (rd_o[1][1] !== 16'h0020) begin n_fail++; $display("FAIL rdw_new: got %h want 0020", rd_o[1][1]); end
        drive(1, 1'b0, 4'd5, 16'h0, 2'b00);
        tick();
        idle();
        n_run++; if (rd_o[0][1] !== 16'h0020) begin n_fail++; $display("FAIL write_visible_a: got %h want 0020", rd_o[0][1]); end
        tick();
        n_run++; if (rd_o[1][1] !== 16'h0020) begin n_fail++; $display("FAIL write_visible_b: got %h want 0020", rd_o[1][1]); end
    endtask

    task automatic test_collision();
        idle();
        drive(0, 1'b1, 4'd7, 16'hAAAA, 2'b11);
        drive(1, 1'b1, 4'd7, 16'h5555, 2'b11);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            n_run++; if (col_o[i] !== 1'b1) begin n_fail++; $display("FAIL collision_pulse inst%0d: got %b want 1", i, col_o[i]); end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++; if (col_o[i] !== 1'b0) begin n_fail++; $display("FAIL collision_one_cycle inst%0d: got %b want 0", i, col_o[i]); end
        end
        drive(0, 1'b0, 4'd7, 16'h0, 2'b00);
        tick();
        idle();
        n_run++; if (rd_o[0][0] !== 16'h5555) begin n_fail++; $display("FAIL collision_prio1: got %h want 5555", rd_o[0][0]); end
        tick();
        n_run++; if (rd_o[1][0] !== 16'hAAAA) begin n_fail++; $display("FAIL collision_prio0: got %h want aaaa", rd_o[1][0]); end
        drive(0, 1'b1, 4'd7, 16'hAAAA, 2'b10);
        drive(1, 1'b1, 4'd7, 16'h5555, 2'b01);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            n_run++; if (col_o[i] !== 1'b0) begin n_fail++; $display("FAIL merge_no_flag inst%0d: got %b want 0", i, col_o[i]); end
        end
        drive(0, 1'b0, 4'd7, 16'h0, 2'b00);
        tick();
        idle();
        n_run++; if (rd_o[0][0] !== 16'hAA55) begin n_fail++; $display("FAIL merge_a: got %h want aa55", rd_o[0][0]); end
        tick();
        n_run++; if (rd_o[1][0] !== 16'hAA55) begin n_fail++; $display("FAIL merge_b: got %h want aa55", rd_o[1][0]); end
    endtask

    task automatic test_reset_mid_clear();
        int rise [2];
        idle();
        drive(1, 1'b0, 4'd7, 16'h0, 2'b00);
        tick();
        rst = 1'b1;
        idle();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_run++; if (vld_o[i][1] !== 1'b0 || rd_o[i][1] !== 16'h0 || rdy_o[i] !== 1'b0) begin n_fail++;
                $display("FAIL reset_flush inst%0d: got v%b d%h r%b want v0 d0000 r0", i, vld_o[i][1], rd_o[i][1], rdy_o[i]); end
        end
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            drive(0, 1'b1, 4'(n), 16'h7777, 2'b11);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rise = '{0, 0};
        for (int n = 1; n <= 40; n++) begin
            if (n <= 12) drive(0, 1'b1, 4'((n - 1) % 12), 16'h7777, 2'b11);
            else idle();
            tick();
            for (int i = 0; i < 2; i++) if (rise[i] == 0 && rdy_o[i] === 1'b1) rise[i] = n;
            if (rise[0] != 0 && rise[1] != 0) break;
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            n_run++; if (rise[i] != DEP[i]) begin n_fail++; $display("FAIL restart_duration inst%0d: got %0d want %0d", i, rise[i], DEP[i]); end
        end
        drive(1, 1'b0, 4'd0, 16'h0, 2'b00);
        tick();
        drive(1, 1'b0, 4'd7, 16'h0, 2'b00);
        n_run++; if (rd_o[0][1] !== 16'hA5A5) begin n_fail++; $display("FAIL recleared_a0: got %h want a5a5", rd_o[0][1]); end
        tick();
        idle();
        n_run++; if (rd_o[0][1] !== 16'hA5A5) begin n_fail++; $display("FAIL recleared_a7: got %h want a5a5", rd_o[0][1]); end
        n_run++; if (rd_o[1][1] !== 16'h3C3C) begin n_fail++; $display("FAIL recleared_b0: got %h want 3c3c", rd_o[1][1]); end
        tick();
        n_run++; if (rd_o[1][1] !== 16'h3C3C) begin n_fail++; $display("FAIL recleared_b7: got %h want 3c3c", rd_o[1][1]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 2; p++) begin
                en[p] = ($urandom_range(0, 3) != 0);
                wr[p] = $urandom_range(0, 1);
                addr[p] = 4'($urandom_range(0, 15));
                wd[p] = 16'($urandom);
                be[p] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 2) == 0) addr[1] = addr[0];
            tick();
            for (int i = 0; i < 2; i++) begin
                n_run++; if (rdy_o[i] !== e_rdy[i]) begin n_fail++; $display("FAIL rand_ready c%0d inst%0d: got %b want %b", c, i, rdy_o[i], e_rdy[i]); end
                n_run++; if (col_o[i] !== e_col[i]) begin n_fail++; $display("FAIL rand_collision c%0d inst%0d: got %b want %b", c, i, col_o[i], e_col[i]); end
                for (int p = 0; p < 2; p++) begin
                    n_run++; if (vld_o[i][p] !== e_vld[i][p]) begin n_fail++;
                        $display("FAIL rand_valid c%0d inst%0d port%0d: got %b want %b", c, i, p, vld_o[i][p], e_vld[i][p]); end
                    n_run++; if (rd_o[i][p] !== e_dat[i][p]) begin n_fail++;
                        $display("FAIL rand_data c%0d inst%0d port%0d: got %h want %h", c, i, p, rd_o[i][p], e_dat[i][p]); end
                end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_byte_enable();
        test_read_during_write();
        test_collision();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/synchronous_true_dual_port_ram.md
# synchronous_true_dual_port_ram

Single-clock true dual-port RAM with two independent read-write ports, per-byte write enables, selectable cross-port read-during-write behaviour, deterministic write-write collision resolution and a hardware clear sequencer that initialises every word after reset. It is the next-generation dual-port memory for single-clock-domain users such as register files, scratchpads and shared descriptor tables. Read latency is configurable (1 or 2 cycles), and a `read_valid` strobe is aligned with the data.

## Interface
- `WIDTH`, 8, word width; must be a multiple of `BYTE_WIDTH`.
- `DEPTH`, 16, number of words; must be ≥ 2; need not be a power of two.
- `BYTE_WIDTH`, 8, write-enable granularity in bits.
- `OUTPUT_REGISTER`, 0, 0 gives read latency 1; 1 adds an output stage for latency 2.
- `READ_DURING_WRITE`, 0, cross-port same-address behaviour: 0 returns old data, 1 returns new data.
- `COLLISION_PRIORITY`, 0, port whose bytes win a write-write collision (0 or 1).
- `RESET_VALUE`, 0, WIDTH-bit value written to every word by the clear sequencer.
- `ADDRESS_WIDTH`, `CLOG2(DEPTH)`, derived.
- `BYTE_COUNT`, WIDTH/BYTE_WIDTH, derived.

Ports:
- `clock` in 1: the only clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `ready` out 1: high once the clear sequence is complete.
- `port_N_access_enable` in 1: access request on port N (N = 0, 1).
- `port_N_write` in 1: 1 = write, 0 = read.
- `port_N_address` in ADDRESS_WIDTH: word address.
- `port_N_write_data` in WIDTH: write data.
- `port_N_byte_enable` in BYTE_COUNT: per-byte write mask; ignored on reads.
- `port_N_read_data` out WIDTH: read result.
- `port_N_read_valid` out 1: `port_N_read_data` is valid this cycle.
- `write_collision` out 1: one-cycle pulse flagging overlapping same-address writes.

## Operation
- **Clear FSM**
  - States: CLEARING and READY.
  - `reset` forces CLEARING with the counter at 0.
  - In CLEARING, each cycle writes RESET_VALUE to word[counter] and increments the counter.
  - At counter == DEPTH-1 the FSM writes the last word and moves to READY on the next edge.
  - READY is absorbing until the next `reset`.
  - Asserting `reset` during CLEARING or READY restarts the clear from word 0.
- **While CLEARING**
  - All port accesses are ignored: no writes, no read_valid, no collision.
  - `ready` = 0.
- **Write**
  - access_enable & write & ready: bytes with byte_enable=1 are updated; other bytes are kept.
- **Read**
  - access_enable & ~write & ready: starts a read; data follows after the configured latency.
  - A write access on a port never produces read_valid on that port.
- **Cross-port read-during-write** (port A reads address X while port B writes X in the same cycle)
  - READ_DURING_WRITE=0: port A returns the pre-write word.
  - READ_DURING_WRITE=1: port A returns the post-write word, byte-merged using B's byte_enable.
- **Write-write collision** (both ports write the same address in the same cycle)
  - Bytes enabled on only one port take that port's data.
  - Bytes enabled on both ports take the data of port COLLISION_PRIORITY.
  - `write_collision` pulses one cycle later only if the byte_enable masks overlap.
  - A non-overlapping mask means the two writes merge cleanly, with no flag.
- **Out-of-range address** (address ≥ DEPTH)
  - Writes are dropped.
  - Reads complete with read_valid=1 and read_data = 0.
- **Read data hold**
  - read_data holds its last value when read_valid=0.

## Timing
- **Reset values:** `ready`=0, both `read_valid`=0, both `read_data`=0, `write_collision`=0, clear counter=0.
- **Clear duration:** `ready` rises exactly DEPTH cycles after the cycle in which `reset` is deasserted.
- **Read latency:** a request at edge k gives data and read_valid at edge k+1 (OUTPUT_REGISTER=0) or k+2 (OUTPUT_REGISTER=1).
- **Throughput:** fully pipelined; one access per port per cycle, with no stalls.
- **Write visibility:** a write at edge k is visible to any read issued at edge k+1 or later.
- **Reset mid-pipeline:** in-flight reads are discarded and read_valid=0 from the edge following reset.
- **write_collision timing:** registered; asserted for exactly one cycle per colliding edge.

## Structure
- **Shared constants** (in the codebase's shared memory header):
  - READ_DURING_WRITE encodings OLD=0 and NEW=1.
  - COLLISION_PRIORITY encodings.
  - The `CLOG2` macro, already shared.
- **Sub-module `memory_clear_sequencer`:** contains the FSM, counter, `ready`, clear address and clear write strobe, parametrised by DEPTH. It is reused by future single-port and FIFO memories.
- **Top level:** contains the array, the per-port read pipelines (generate on OUTPUT_REGISTER), the collision and merge logic, and the range checks.

## Test plan
- **Clear sequence:** DEPTH=16, RESET_VALUE=8'hA5; deassert reset; poll `ready`.
  - `ready`=1 exactly 16 cycles later.
  - Reading every address returns A5 with read_valid at latency 1.
- **Byte-enable write:** WIDTH=32; port 0 writes 0x11223344 to address 3 with byte_enable=4'b0101 over an array cleared to 0.
  - Port 1 read of address 3 returns 0x00220044.
- **Cross-port read-during-write:** word 5 = 0x10; port 0 writes 0x20 to address 5 while port 1 reads address 5 in the same cycle.
  - READ_DURING_WRITE=0 returns 0x10.
  - READ_DURING_WRITE=1 returns 0x20.
- **Write-write collision:** COLLISION_PRIORITY=1; port 0 writes 0xAAAA and port 1 writes 0x5555 to address 7, both with byte_enable=2'b11.
  - Word 7 becomes 0x5555.
  - `write_collision` pulses once, one cycle later.
  - Repeating with masks 2'b10 / 2'b01 gives 0xAA55 and no pulse.
- **Access and reset during clearing:** writes issued during CLEARING are discarded; reset is reasserted mid-clear.
  - Clearing restarts and `ready` rises DEPTH cycles after the new deassertion.
  - Reads return RESET_VALUE.
- **Pipelining and out-of-range:** OUTPUT_REGISTER=1, DEPTH=12; back-to-back reads of addresses 0..11 plus address 13.
  - One read_valid per cycle at latency 2, with in-order data.
  - Address 13 returns 0 with read_valid=1.
